x2050_hreg_stack: RTL and testbench
===================================

Name: x2050_hreg_stack

Overview:
- Parametrised successor to the 2050 H register.
- Holds a WIDTH-bit H value plus a DEPTH-entry save stack, so microcode can nest H usage (push/pop/swap).
- Generalises the fixed IAR and T0-nibble loads into a source-select plus arbitrary-field insert.
- All updates are gated by the ROS advance strobe; sits beside the T/IAR datapath and feeds the adder/mover like the H register.

Parameters:
- WIDTH, 32, H and stack entry width in bits.
- DEPTH, 4, number of stack entries (>=1).
- IAR_W, 24, width of the IAR source; zero-extended to WIDTH.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ros_advance  in  1  update enable; no state changes when low.
- i_op  in  3  operation: 0 NOP, 1 LOAD, 2 FIELD, 3 PUSHLD, 4 POP, 5 CLEAR, 6 SWAP, 7 NOP.
- i_src  in  2  source: 0 i_t_reg, 1 i_t0, 2 i_iar (zero-extended), 3 zero.
- i_t_reg  in  WIDTH  T register.
- i_t0  in  WIDTH  T0 (adder output).
- i_iar  in  IAR_W  instruction address register.
- i_fld_lo  in  $clog2(WIDTH)  FIELD destination LSB (Verilog bit 0 = IBM bit WIDTH-1).
- i_fld_len  in  $clog2(WIDTH)+1  FIELD length in bits.
- i_err_clr  in  1  clears sticky error flags.
- o_h_reg  out  WIDTH  current H value.
- o_depth  out  $clog2(DEPTH+1)  number of occupied entries.
- o_empty  out  1  o_depth==0.
- o_full  out  1  o_depth==DEPTH.
- o_ovf  out  1  sticky push-when-full.
- o_unf  out  1  sticky pop/swap-when-empty.

Behaviour:
- Clocking: all state updates on posedge i_clk. Single clock; reset is synchronous, active-high.
- Reset: o_h_reg=0, o_depth=0, stack contents zeroed, o_ovf=0, o_unf=0. Reset overrides everything, including mid-sequence ops.
- Gating: when i_ros_advance=0, nothing changes except i_err_clr handling, which is ungated.
- Latency: one cycle. The op sampled at the edge is visible on outputs after that edge. o_empty/o_full derive combinationally from o_depth.
- LOAD: H <= src.
- FIELD: H[lo+k] <= src[k] for k=0..len-1; other H bits are held.
  - len=0: no change.
  - Bits with lo+k >= WIDTH are dropped (no wrap).
  - i_fld_len > WIDTH is treated as WIDTH.
- PUSHLD: push the old H, then H <= src.
  - If full: H is still loaded, stack unchanged, o_ovf set.
- POP: H <= top entry; depth decrements.
  - If empty: H unchanged, o_unf set.
- CLEAR: H <= 0. Stack and depth untouched.
- SWAP: H and the top entry exchange values; depth unchanged.
  - If empty: no change, o_unf set.
- Stack: a LIFO with an explicit depth counter; the top is entry depth-1. Entries above depth are don't-care to the outside but must never be presented on o_h_reg.
- Error flags: o_ovf and o_unf stay set until reset or i_err_clr. If i_err_clr and a new error occur in the same cycle, the flag ends set (set wins).
- Depth arithmetic: no wrap. Saturates at 0 and at DEPTH.

Optional Feature:
- Macro: X2050_HREG_PARITY_EN.
- Defined:
  - Each H byte and each stack entry carries an odd-parity bit, generated on every write into H.
  - On POP/SWAP, the parity stored with the popped entry is checked. A mismatch sets sticky output o_perr (1 bit, reset 0, cleared by i_err_clr), and H is still loaded.
  - Adds output o_h_par [WIDTH/8] (WIDTH must be a multiple of 8).
- Undefined: no parity storage; o_perr and o_h_par ports are absent.

Test Plan:
- Reset, then LOAD src=T with i_t_reg=32'h12345678 and advance=1 -> o_h_reg=32'h12345678, o_depth=0, o_empty=1.
- FIELD src=T0, i_t0=32'h0000000A, lo=28, len=4 on H=32'h00000000 -> H=32'hA0000000. Repeat with lo=30, len=4 -> H=32'h80000000 (upper bits dropped).
- PUSHLD src=IAR (i_iar=24'hABCDEF) four times from H=32'h11111111 -> depth=4, o_full=1. A fifth PUSHLD with i_iar=24'h000001 -> H=32'h00000001, o_ovf=1, depth=4.
- Continuing from the previous case, POP x4 -> H sequence 32'h00ABCDEF x3, then 32'h11111111; o_empty=1. A fifth POP -> H unchanged, o_unf=1. Then i_err_clr=1 with advance=0 -> o_ovf=o_unf=0.
- H=32'h5 with stack top 32'h9, SWAP -> H=32'h9, top=32'h5. Same op with advance=0 -> no change. Assert reset mid-sequence -> all outputs 0 next cycle.
- With X2050_HREG_PARITY_EN: PUSHLD, then force-flip one bit of the top entry, POP -> o_perr=1, H=corrupted value.

Source files
------------

// File: rtl/x2050_hreg_stack_if.sv
// ============================================================================
// x2050_hreg_stack_if
// Control/data bundle between microcode sequencing and the H register stack.
// Optional macro X2050_HREG_PARITY_EN adds o_perr and o_h_par.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface x2050_hreg_stack_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IAR_W = 24
);
  localparam int LW = $clog2(WIDTH);
  localparam int DW = $clog2(DEPTH + 1);

  logic             i_ros_advance;
  logic [2:0]       i_op;
  logic [1:0]       i_src;
  logic [WIDTH-1:0] i_t_reg;
  logic [WIDTH-1:0] i_t0;
  logic [IAR_W-1:0] i_iar;
  logic [LW-1:0]    i_fld_lo;
  logic [LW:0]      i_fld_len;
  logic             i_err_clr;
  logic [WIDTH-1:0] o_h_reg;
  logic [DW-1:0]    o_depth;
  logic             o_empty;
  logic             o_full;
  logic             o_ovf;
  logic             o_unf;
`ifdef X2050_HREG_PARITY_EN
  logic                 o_perr;
  logic [WIDTH/8-1:0]   o_h_par;
`endif

  modport master (
    output i_ros_advance, i_op, i_src, i_t_reg, i_t0, i_iar,
           i_fld_lo, i_fld_len, i_err_clr,
`ifdef X2050_HREG_PARITY_EN
    input  o_perr, o_h_par,
`endif
    input  o_h_reg, o_depth, o_empty, o_full, o_ovf, o_unf
  );

  modport slave (
    input  i_ros_advance, i_op, i_src, i_t_reg, i_t0, i_iar,
           i_fld_lo, i_fld_len, i_err_clr,
`ifdef X2050_HREG_PARITY_EN
    output o_perr, o_h_par,
`endif
    output o_h_reg, o_depth, o_empty, o_full, o_ovf, o_unf
  );
endinterface

`default_nettype wire

// File: rtl/x2050_hreg_stack.sv
// ============================================================================
// x2050_hreg_stack
// H register with a DEPTH-entry LIFO save stack, source select and field insert.
// Optional macro X2050_HREG_PARITY_EN: odd parity per byte on H and stack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module x2050_hreg_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int IAR_W = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  x2050_hreg_stack_if.slave    bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(WIDTH);

  localparam logic [2:0] C_OP_LOAD   = 3'd1;
  localparam logic [2:0] C_OP_FIELD  = 3'd2;
  localparam logic [2:0] C_OP_PUSHLD = 3'd3;
  localparam logic [2:0] C_OP_POP    = 3'd4;
  localparam logic [2:0] C_OP_CLEAR  = 3'd5;
  localparam logic [2:0] C_OP_SWAP   = 3'd6;

  logic [WIDTH-1:0] r_h;
  logic [DW-1:0]    r_depth;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_src_sh;
  logic [WIDTH-1:0] w_fmask;
  logic [LW:0]      w_len_eff;
  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_top_idx;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_h_nxt;
  logic [DW-1:0]    w_depth_nxt;
  logic             w_stk_we;
  logic [PW-1:0]    w_stk_idx;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_chk;

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_top_idx = PW'(r_depth - DW'(1));
  assign w_top     = r_stack[w_top_idx];

  always_comb begin
    w_src = '0;
    case (bus.i_src)
      2'd0:    w_src = bus.i_t_reg;
      2'd1:    w_src = bus.i_t0;
      2'd2:    w_src = WIDTH'(bus.i_iar);
      default: w_src = '0;
    endcase
  end

  // Field insert: shifted source under a mask of len bits starting at lo;
  // bits shifted past the MSB simply fall off.
  assign w_len_eff = (bus.i_fld_len > (LW+1)'(WIDTH)) ? (LW+1)'(WIDTH) : bus.i_fld_len;
  assign w_src_sh  = w_src << bus.i_fld_lo;

  always_comb begin
    w_fmask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_fmask[i] = (i >= int'(bus.i_fld_lo)) &&
                   ((i - int'(bus.i_fld_lo)) < int'(w_len_eff));
    end
  end

  always_comb begin
    w_h_nxt     = r_h;
    w_depth_nxt = r_depth;
    w_stk_we    = 1'b0;
    w_stk_idx   = w_top_idx;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    w_chk       = 1'b0;
    if (bus.i_ros_advance) begin
      case (bus.i_op)
        C_OP_LOAD:  w_h_nxt = w_src;
        C_OP_FIELD: w_h_nxt = (r_h & ~w_fmask) | (w_src_sh & w_fmask);
        C_OP_PUSHLD: begin
          w_h_nxt = w_src;
          if (w_full) begin
            w_ovf_evt = 1'b1;
          end else begin
            w_stk_we    = 1'b1;
            w_stk_idx   = PW'(r_depth);
            w_depth_nxt = r_depth + DW'(1);
          end
        end
        C_OP_POP: begin
          if (w_empty) begin
            w_unf_evt = 1'b1;
          end else begin
            w_h_nxt     = w_top;
            w_depth_nxt = r_depth - DW'(1);
            w_chk       = 1'b1;
          end
        end
        C_OP_CLEAR: w_h_nxt = '0;
        C_OP_SWAP: begin
          if (w_empty) begin
            w_unf_evt = 1'b1;
          end else begin
            w_h_nxt  = w_top;
            w_stk_we = 1'b1;
            w_chk    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Error flags are updated outside the advance gate so err_clr always works.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h     <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_h     <= w_h_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_evt | (r_ovf & ~bus.i_err_clr);
      r_unf   <= w_unf_evt | (r_unf & ~bus.i_err_clr);
      if (w_stk_we) r_stack[w_stk_idx] <= r_h;
    end
  end

  assign bus.o_h_reg = r_h;
  assign bus.o_depth = r_depth;
  assign bus.o_empty = w_empty;
  assign bus.o_full  = w_full;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_unf   = r_unf;

`ifdef X2050_HREG_PARITY_EN
  localparam int NB = WIDTH / 8;

  logic [NB-1:0] r_h_par;
  logic [NB-1:0] r_spar [DEPTH];
  logic          r_perr;

  function automatic logic [NB-1:0] f_par(input logic [WIDTH-1:0] v);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ~^v[8*b +: 8];
    return p;
  endfunction

  // The stored parity travels with the data; recomputing on read exposes corruption.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_par <= f_par('0);
      r_perr  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_spar[i] <= f_par('0);
    end else begin
      r_h_par <= f_par(w_h_nxt);
      r_perr  <= (w_chk && (f_par(w_top) != r_spar[w_top_idx])) |
                 (r_perr & ~bus.i_err_clr);
      if (w_stk_we) r_spar[w_stk_idx] <= r_h_par;
    end
  end

  assign bus.o_perr  = r_perr;
  assign bus.o_h_par = r_h_par;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x2050_hreg_stack.sv
// Self-checking bench for x2050_hreg_stack: queue-based reference model checked
// every cycle, plus literal expectations from hand-worked cases.
`default_nettype none

module tb_x2050_hreg_stack;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int IAR_W = 24;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;

  x2050_hreg_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IAR_W(IAR_W)) bus ();

  x2050_hreg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IAR_W(IAR_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [31:0] m_h;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  function automatic logic [31:0] src_val();
    case (bus.i_src)
      2'd0:    return bus.i_t_reg;
      2'd1:    return bus.i_t0;
      2'd2:    return {8'h00, bus.i_iar};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] s;
    logic [31:0] tmp;
    bit ovf_e, unf_e;
    int len;
    s = src_val();
    ovf_e = 0;
    unf_e = 0;
    if (rst) begin
      m_h = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      return;
    end
    if (bus.i_ros_advance) begin
      case (bus.i_op)
        3'd1: m_h = s;
        3'd2: begin
          len = (int'(bus.i_fld_len) > 32) ? 32 : int'(bus.i_fld_len);
          for (int k = 0; k < len; k++)
            if (int'(bus.i_fld_lo) + k < 32) m_h[int'(bus.i_fld_lo) + k] = s[k];
        end
        3'd3: begin
          if (m_stk.size() == DEPTH) ovf_e = 1; else m_stk.push_back(m_h);
          m_h = s;
        end
        3'd4: if (m_stk.size() == 0) unf_e = 1; else m_h = m_stk.pop_back();
        3'd5: m_h = 0;
        3'd6: begin
          if (m_stk.size() == 0) unf_e = 1;
          else begin
            tmp = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = m_h;
            m_h = tmp;
          end
        end
        default: ;
      endcase
    end
    m_ovf = ovf_e | (m_ovf & ~bus.i_err_clr);
    m_unf = unf_e | (m_unf & ~bus.i_err_clr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_h",     bus.o_h_reg, m_h);
      check("cyc_depth", 32'(bus.o_depth), 32'(m_stk.size()));
      check("cyc_empty", 32'(bus.o_empty), 32'(m_stk.size() == 0));
      check("cyc_full",  32'(bus.o_full),  32'(m_stk.size() == DEPTH));
      check("cyc_ovf",   32'(bus.o_ovf), 32'(m_ovf));
      check("cyc_unf",   32'(bus.o_unf), 32'(m_unf));
    end
  end

  // Inputs change only right after the negedge, so sampling them after the posedge is safe.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [1:0] s, input logic adv);
    bus.i_op = o;
    bus.i_src = s;
    bus.i_ros_advance = adv;
    step();
    bus.i_ros_advance = 1'b0;
    bus.i_op = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_ros_advance = 0; bus.i_op = 0; bus.i_src = 0;
    bus.i_t_reg = 32'hDEADBEEF; bus.i_t0 = 0; bus.i_iar = 0;
    bus.i_fld_lo = 0; bus.i_fld_len = 0; bus.i_err_clr = 0;
    m_h = 0; m_ovf = 0; m_unf = 0;
    step();
    step();
    chk_en = 1;
    rst = 1'b0;
    check("rst_h", bus.o_h_reg, 32'h0);
    check("rst_empty", 32'(bus.o_empty), 32'd1);

    bus.i_t_reg = 32'h12345678;
    op(3'd1, 2'd0, 1'b1);
    check("load_h", bus.o_h_reg, 32'h12345678);
    check("load_depth", 32'(bus.o_depth), 32'd0);

    bus.i_t_reg = 32'hCAFEF00D;
    op(3'd1, 2'd0, 1'b0);
    check("gated_load", bus.o_h_reg, 32'h12345678);

    op(3'd5, 2'd0, 1'b1);
    bus.i_t0 = 32'h0000000A; bus.i_fld_lo = 5'd28; bus.i_fld_len = 6'd4;
    op(3'd2, 2'd1, 1'b1);
    check("field_28", bus.o_h_reg, 32'hA0000000);
    op(3'd5, 2'd0, 1'b1);
    bus.i_fld_lo = 5'd30;
    op(3'd2, 2'd1, 1'b1);
    check("field_drop", bus.o_h_reg, 32'h80000000);
    bus.i_fld_len = 6'd0;
    op(3'd2, 2'd1, 1'b1);
    check("field_len0", bus.o_h_reg, 32'h80000000);
    bus.i_t_reg = 32'h0F0F1234; bus.i_fld_lo = 5'd0; bus.i_fld_len = 6'd40;
    op(3'd2, 2'd0, 1'b1);
    check("field_clamp", bus.o_h_reg, 32'h0F0F1234);
    bus.i_fld_lo = 5'd8; bus.i_fld_len = 6'd8; bus.i_t0 = 32'h000000C3;
    op(3'd2, 2'd1, 1'b1);
    check("field_mid", bus.o_h_reg, 32'h0F0FC334);

    bus.i_t_reg = 32'h11111111;
    op(3'd1, 2'd0, 1'b1);
    bus.i_iar = 24'hABCDEF;
    for (int i = 0; i < 4; i++) op(3'd3, 2'd2, 1'b1);
    check("push_full", 32'(bus.o_full), 32'd1);
    check("push_depth", 32'(bus.o_depth), 32'd4);
    bus.i_iar = 24'h000001;
    op(3'd3, 2'd2, 1'b1);
    check("ovf_h", bus.o_h_reg, 32'h00000001);
    check("ovf_flag", 32'(bus.o_ovf), 32'd1);
    check("ovf_depth", 32'(bus.o_depth), 32'd4);

    for (int i = 0; i < 3; i++) begin
      op(3'd4, 2'd0, 1'b1);
      check("pop_iar", bus.o_h_reg, 32'h00ABCDEF);
    end
    op(3'd4, 2'd0, 1'b1);
    check("pop_last", bus.o_h_reg, 32'h11111111);
    check("pop_empty", 32'(bus.o_empty), 32'd1);
    op(3'd4, 2'd0, 1'b1);
    check("unf_h", bus.o_h_reg, 32'h11111111);
    check("unf_flag", 32'(bus.o_unf), 32'd1);
    bus.i_err_clr = 1'b1;
    op(3'd0, 2'd0, 1'b0);
    bus.i_err_clr = 1'b0;
    check("clr_ovf", 32'(bus.o_ovf), 32'd0);
    check("clr_unf", 32'(bus.o_unf), 32'd0);

    bus.i_err_clr = 1'b1;
    op(3'd6, 2'd0, 1'b1);
    bus.i_err_clr = 1'b0;
    check("set_wins", 32'(bus.o_unf), 32'd1);

    bus.i_t_reg = 32'h9;
    op(3'd1, 2'd0, 1'b1);
    bus.i_t_reg = 32'h5;
    op(3'd3, 2'd0, 1'b1);
    op(3'd6, 2'd0, 1'b1);
    check("swap_h", bus.o_h_reg, 32'h9);
    check("swap_depth", 32'(bus.o_depth), 32'd1);
    op(3'd6, 2'd0, 1'b0);
    check("swap_gated", bus.o_h_reg, 32'h9);
    op(3'd4, 2'd0, 1'b1);
    check("swap_top", bus.o_h_reg, 32'h5);

`ifdef X2050_HREG_PARITY_EN
    check("perr_idle", 32'(bus.o_perr), 32'd0);
    bus.i_t_reg = 32'h77;
    op(3'd3, 2'd0, 1'b1);
    dut.r_stack[0][3] = ~dut.r_stack[0][3];
    op(3'd4, 2'd0, 1'b1);
    check("perr_flag", 32'(bus.o_perr), 32'd1);
    check("perr_h", bus.o_h_reg, 32'h0000000D);
    chk_en = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1;
`endif

    bus.i_t_reg = 32'h3C3C3C3C;
    op(3'd3, 2'd0, 1'b1);
    op(3'd3, 2'd0, 1'b1);
    rst = 1'b1;
    op(3'd3, 2'd0, 1'b1);
    rst = 1'b0;
    check("midrst_h", bus.o_h_reg, 32'h0);
    check("midrst_depth", 32'(bus.o_depth), 32'd0);
    check("midrst_ovf", 32'(bus.o_ovf), 32'd0);
    check("midrst_unf", 32'(bus.o_unf), 32'd0);

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
